// File: rtl/det_pkg.sv
// Shared types and defaults for the serial pattern-detector datapath.
package det_pkg;

  localparam int DET_DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    SER_IDLE   = 2'd0,
    SER_SHIFT  = 2'd1,
    SER_PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/byte_serializer.sv
// Word-to-bit serializer, MSB first, gapless across back-to-back words.
// Optional trailing even-parity bit per word with BYTE_SERIALIZER_PARITY_EN.
module byte_serializer
  import det_pkg::*;
#(
  parameter int   DATA_W   = DET_DATA_W_DEFAULT,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy
);

  localparam int            CW       = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  ser_state_t        state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
  logic              ser_out_nxt, ser_valid_nxt;
  logic              last_bit, ready_raw, accept;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic              par_q;
`endif

  assign last_bit = (bit_cnt == LAST_CNT);
  assign s_ready  = rstn & ready_raw;
  assign accept   = s_valid & s_ready;
  assign busy     = (state != SER_IDLE);

  // Ready opens on the slot whose edge frees the shifter, so a reload lands gaplessly.
  always_comb begin
    ready_raw = 1'b0;
    case (state)
      SER_IDLE:   ready_raw = 1'b1;
`ifdef BYTE_SERIALIZER_PARITY_EN
      SER_PARITY: ready_raw = 1'b1;
`else
      SER_SHIFT:  ready_raw = last_bit;
`endif
      default:    ready_raw = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    ser_out_nxt   = IDLE_BIT;
    ser_valid_nxt = 1'b0;
    case (state)
      SER_IDLE: state_nxt = SER_IDLE;
      SER_SHIFT: begin
        ser_out_nxt   = shreg[DATA_W-1];
        ser_valid_nxt = 1'b1;
        shreg_nxt     = {shreg[DATA_W-2:0], 1'b0};
        if (!last_bit) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end else begin
`ifdef BYTE_SERIALIZER_PARITY_EN
          state_nxt = SER_PARITY;
`else
          state_nxt = SER_IDLE;
`endif
        end
      end
`ifdef BYTE_SERIALIZER_PARITY_EN
      SER_PARITY: begin
        ser_out_nxt   = par_q;
        ser_valid_nxt = 1'b1;
        state_nxt     = SER_IDLE;
      end
`endif
      default: state_nxt = SER_IDLE;
    endcase
    // Acceptance is only possible in states that are ending a word, so it overrides.
    if (accept) begin
      state_nxt   = SER_SHIFT;
      shreg_nxt   = s_data;
      bit_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= SER_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ser_out   <= ser_out_nxt;
      ser_valid <= ser_valid_nxt;
    end
  end

`ifdef BYTE_SERIALIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^s_data;
    end
  end
`endif

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: bit-queue reference model plus directed and random scenarios.
module tb_byte_serializer;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready, ser_out, ser_valid, busy;

  byte_serializer #(.DATA_W(DATA_W), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of bits still owed to the stream.
  logic        pend[$];
  logic        mdl_rdy, mdl_acc, seen_rdy;
  logic        exp_out = 1'b0, exp_vld = 1'b0, exp_busy = 1'b0;
  logic [63:0] obs_vec;
  int          obs_n, cyc, first_v, last_v, rdy_hits;

  task automatic clear_obs();
    obs_vec = '0; obs_n = 0; first_v = -1; last_v = -1; rdy_hits = 0;
  endtask

  task automatic tick();
    logic [DATA_W-1:0] w;
    #1;
    mdl_rdy  = rstn && (pend.size() <= 1);
    seen_rdy = s_ready;
    mdl_acc  = s_valid && mdl_rdy;
    if (s_valid && seen_rdy) rdy_hits++;
    w = s_data;
    @(posedge clk);
    if (!rstn) begin
      pend.delete();
      exp_out = 1'b0; exp_vld = 1'b0;
    end else begin
      if (pend.size() > 0) begin
        exp_out = pend.pop_front(); exp_vld = 1'b1;
      end else begin
        exp_out = 1'b0; exp_vld = 1'b0;
      end
      if (mdl_acc) begin
        for (int i = DATA_W - 1; i >= 0; i--) pend.push_back(w[i]);
`ifdef BYTE_SERIALIZER_PARITY_EN
        pend.push_back(^w);
`endif
      end
    end
    exp_busy = (pend.size() != 0);
    @(negedge clk);
    cyc++;
    if (ser_valid === 1'b1) begin
      obs_vec = {obs_vec[62:0], ser_out};
      obs_n++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b1; s_data = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({seen_rdy, ser_valid, ser_out, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset cyc=%0d rdy/vld/out/busy got %b%b%b%b exp 0000", i, seen_rdy, ser_valid, ser_out, busy);
      end
    end
    rstn = 1'b1; s_valid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release s_ready got %b exp 1", s_ready);
    end
    tick();
  endtask

  task automatic test_single();
    clear_obs();
    s_data = 8'hB0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({ser_out, ser_valid, busy} !== {exp_out, exp_vld, exp_busy}) begin
        errors++;
        $display("FAIL single cyc=%0d out/vld/busy got %b%b%b exp %b%b%b", i, ser_out, ser_valid, busy, exp_out, exp_vld, exp_busy);
      end
    end
    checks++;
`ifdef BYTE_SERIALIZER_PARITY_EN
    if (obs_n != 9 || obs_vec[8:0] !== 9'b1011_0000_1) begin
`else
    if (obs_n != 8 || obs_vec[7:0] !== 8'b1011_0000) begin
`endif
      errors++;
      $display("FAIL single_stream got n=%0d bits=%h", obs_n, obs_vec);
    end
    checks++;
    if ({ser_valid, ser_out} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle vld/out got %b%b exp 00", ser_valid, ser_out);
    end
  endtask

  // Offers w0 then w1 with s_valid held high; w1 is presented after w0 has gap_bits left.
  task automatic run_pair(input logic [7:0] w0, input logic [7:0] w1, input int gap_bits,
                          input string name);
    int n_acc;
    clear_obs();
    n_acc = 0;
    s_data = w0; s_valid = 1'b1;
    for (int i = 0; i < 40 && n_acc < 2; i++) begin
      tick();
      checks++;
      if ({seen_rdy, ser_out, ser_valid, busy} !== {mdl_rdy, exp_out, exp_vld, exp_busy}) begin
        errors++;
        $display("FAIL %s cyc=%0d rdy/out/vld/busy got %b%b%b%b exp %b%b%b%b", name, i,
                 seen_rdy, ser_out, ser_valid, busy, mdl_rdy, exp_out, exp_vld, exp_busy);
      end
      if (mdl_acc) begin
        n_acc++;
        s_data = w1;
        if (gap_bits > 0) s_valid = 1'b0;
      end
      if (n_acc == 1 && !s_valid && pend.size() <= gap_bits) s_valid = 1'b1;
    end
    s_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (n_acc != 2 || rdy_hits != 2) begin
      errors++;
      $display("FAIL %s_accepts got model=%0d dut=%0d exp 2", name, n_acc, rdy_hits);
    end
    checks++;
    if (last_v - first_v + 1 != obs_n) begin
      errors++;
      $display("FAIL %s_gapless span=%0d bits=%0d", name, last_v - first_v + 1, obs_n);
    end
  endtask

  task automatic test_back_to_back();
    run_pair(8'hBB, 8'h0B, 0, "b2b");
    checks++;
`ifdef BYTE_SERIALIZER_PARITY_EN
    if (obs_n != 18 || obs_vec[17:0] !== {8'hBB, 1'b0, 8'h0B, 1'b1}) begin
`else
    if (obs_n != 16 || obs_vec[15:0] !== 16'b1011_1011_0000_1011) begin
`endif
      errors++;
      $display("FAIL b2b_stream got n=%0d bits=%h", obs_n, obs_vec);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w0;
    w0 = 8'($urandom);
    run_pair(w0, 8'h5A, 4, "bp");
    checks++;
`ifdef BYTE_SERIALIZER_PARITY_EN
    if (obs_n != 18 || obs_vec[17:0] !== {w0, ^w0, 8'h5A, 1'b0}) begin
`else
    if (obs_n != 16 || obs_vec[15:0] !== {w0, 8'h5A}) begin
`endif
      errors++;
      $display("FAIL bp_stream w0=%h got n=%0d bits=%h", w0, obs_n, obs_vec);
    end
  endtask

`ifdef BYTE_SERIALIZER_PARITY_EN
  task automatic test_parity();
    run_pair(8'hB0, 8'hFF, 0, "par");
    checks++;
    if (obs_n != 18 || obs_vec[17:0] !== {8'hB0, 1'b1, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL par_stream got n=%0d bits=%h", obs_n, obs_vec);
    end
  endtask
`endif

  task automatic test_reset_mid();
    clear_obs();
    s_data = 8'hB0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 20 && obs_n < 3; i++) tick();
    rstn = 1'b0;
    tick();
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid vld/busy got %b%b exp 00", ser_valid, busy);
    end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (obs_n != 3) begin
      errors++;
      $display("FAIL rst_mid_quiet bits got %0d exp 3", obs_n);
    end
    clear_obs();
    s_data = 8'h0B; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
`ifdef BYTE_SERIALIZER_PARITY_EN
    if (obs_n != 9 || obs_vec[8:0] !== {8'h0B, 1'b1}) begin
`else
    if (obs_n != 8 || obs_vec[7:0] !== 8'h0B) begin
`endif
      errors++;
      $display("FAIL rst_mid_fresh got n=%0d bits=%h", obs_n, obs_vec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!s_valid || mdl_acc) s_data = 8'($urandom);
      if (!s_valid || mdl_acc) s_valid = ($urandom_range(0, 3) != 0);
      rstn = ($urandom_range(0, 99) != 0);
      tick();
      checks++;
      if ({seen_rdy, ser_out, ser_valid, busy} !== {mdl_rdy, exp_out, exp_vld, exp_busy}) begin
        errors++;
        $display("FAIL rand cyc=%0d rdy/out/vld/busy got %b%b%b%b exp %b%b%b%b", i,
                 seen_rdy, ser_out, ser_valid, busy, mdl_rdy, exp_out, exp_vld, exp_busy);
      end
    end
    rstn = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  initial begin
    cyc = 0;
    mdl_acc = 1'b0;
    clear_obs();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
`ifdef BYTE_SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Parallel-to-serial front end for the serial pattern-detector datapath. It accepts DATA_W-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single-bit stream with a qualifying valid. Words can be accepted back-to-back, so a continuous byte source produces a gapless bit stream. It sits directly upstream of the sequence detectors: its `ser_out` drives their serial `in` input.

## Interface
- DATA_W, 8, word width; legal range 2..32.
- IDLE_BIT, 1'b0, value driven on `ser_out` when no bit is valid.

Reset is `rstn`, synchronous, active-low. The clock is `clk`.

- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  synchronous active-low reset.
- s_data  input  DATA_W  word to serialize; sampled on acceptance.
- s_valid  input  1  `s_data` is valid.
- s_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit, registered.
- ser_valid  output  1  `ser_out` carries a payload or parity bit, registered.
- busy  output  1  a word is being shifted (state ≠ SER_IDLE), registered.

## Operation
- FSM states: SER_IDLE, SER_SHIFT, SER_PARITY. SER_PARITY exists only with the macro defined.
- Acceptance occurs when `s_valid && s_ready` on a rising edge. `s_data` is loaded into the shift register and `bit_cnt` is cleared to 0.
- `s_ready` is combinational from state only. It never depends on `s_valid`. It is forced to 0 while `rstn` = 0.
  - SER_IDLE: `s_ready` = 1.
  - SER_SHIFT with `bit_cnt` = DATA_W-1 and no parity: `s_ready` = 1.
  - SER_PARITY: `s_ready` = 1.
  - Otherwise: `s_ready` = 0.
- SER_IDLE transitions:
  - On acceptance, go to SER_SHIFT.
  - Otherwise hold, with `ser_valid` = 0 and `ser_out` = IDLE_BIT.
- SER_SHIFT behaviour and transitions:
  - Each cycle, drive the current MSB, shift left, and increment `bit_cnt`.
  - After the last bit (`bit_cnt` = DATA_W-1), go to SER_PARITY if enabled.
  - Otherwise, go to SER_SHIFT on a same-cycle acceptance (reload, `bit_cnt` = 0), else to SER_IDLE.
- SER_PARITY transitions: drive the parity bit, then go to SER_SHIFT on acceptance, else to SER_IDLE.
- `bit_cnt` width is $clog2(DATA_W). It never wraps past DATA_W-1; reload resets it to 0.
- Input is ignored while `s_ready` = 0. The upstream holds `s_data`/`s_valid` stable.
- Reset mid-word: the in-flight word is discarded and no further bits are emitted.
- Reset values:
  - `ser_out` = IDLE_BIT
  - `ser_valid` = 0
  - `busy` = 0
  - `s_ready` = 0 during reset, 1 on the first cycle after release
  - state = SER_IDLE, `bit_cnt` = 0

## Timing
- Word accepted at edge T: `ser_out` = `s_data[DATA_W-1]` with `ser_valid` = 1 from edge T+1.
- Bit k (MSB = 0) appears in the cycle after edge T+1+k. The LSB appears after edge T+DATA_W.
- Parity, when enabled, appears after edge T+DATA_W+1.
- Back-to-back words produce no `ser_valid` gap.
- Throughput:
  - 1 word per DATA_W cycles without parity.
  - 1 word per DATA_W+1 cycles with parity.
- `busy` rises one cycle after acceptance. It falls one cycle after the final bit if no new word was accepted.

## Configuration
- Macro: BYTE_SERIALIZER_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of the word) is appended after the LSB, in SER_PARITY, with `ser_valid` = 1.
  - `s_ready` asserts in SER_PARITY instead of on the last SHIFT cycle.
- Undefined:
  - SER_PARITY and its logic are absent.
  - Words are pure DATA_W-bit bursts.

## Structure
- Shared package `det_pkg` holds the `ser_state_t` enum (SER_IDLE, SER_SHIFT, SER_PARITY) and `DET_DATA_W_DEFAULT` = 8.
- The block is a single module with no sub-module. The shift register, counter and FSM are small enough to stay in one file.

## Test plan
- Reset: hold `rstn` = 0 for 3 cycles with `s_valid` = 1.
  - Required: `s_ready` = 0, `ser_valid` = 0, `ser_out` = 0, `busy` = 0 throughout.
  - Required: `s_ready` = 1 on the first cycle after release.
- Single word: accept 0xB0 (no parity).
  - Required: `ser_out` = 1,0,1,1,0,0,0,0 with `ser_valid` = 1 for exactly 8 cycles, then `ser_valid` = 0 and `ser_out` = IDLE_BIT.
- Back-to-back: stream 0xBB then 0x0B with `s_valid` held high.
  - Required: 16 contiguous valid bits 1011_1011_0000_1011.
  - Required: `s_ready` is high only at first acceptance and on the 8th bit cycle.
- Backpressure: present 0x5A while the previous word has 4 bits left.
  - Required: `s_ready` = 0 until the last bit; 0x5A is not accepted early.
  - Required: its MSB immediately follows the previous LSB.
- Parity (macro defined): accept 0xB0.
  - Required: 9 valid bits 1,0,1,1,0,0,0,0,1 (three ones → parity 1).
  - Then accept 0xFF. Required: trailing parity bit 0.
- Reset mid-word: assert `rstn` = 0 after 3 bits of 0xB0.
  - Required: `ser_valid` = 0 on the next cycle.
  - Required: no further bits appear, and a fresh 0x0B after release serializes cleanly.
